// File: rtl/blue_motion.sv
// -----------------------------------------------------------------------------
// blue_motion
//   Player ("blue") motion controller. Integrates horizontal motion, jump and
//   gravity once per video frame from the player keys and the collision flags
//   produced by the collision block, and drives the player position back to the
//   collision block and to the sprite renderer.
//
// Ports
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous reset, active low
//   frame_tick    in   1   one-cycle pulse per frame; updates happen only then
//   key_left      in   1   level: move left
//   key_right     in   1   level: move right
//   key_jump      in   1   level: jump key (rising edge starts a jump)
//   is_Collision  in   4   [0] floor, [1] head, [2] right wall, [3] left wall
//   x_blue        out  10  player x (sprite top-left), registered
//   y_blue        out  9   player y (sprite top-left), registered
//   state         out  2   0=GROUND, 1=RISE, 2=FALL, registered
//   facing        out  1   0=right, 1=left, registered
//
// Configuration
//   DOUBLE_JUMP_EN  when defined, one extra jump is accepted while airborne.
// -----------------------------------------------------------------------------
module blue_motion #(
    parameter int unsigned X_INIT   = 40,
    parameter int unsigned Y_INIT   = 400,
    parameter int unsigned X_MAX    = 593,
    parameter int unsigned Y_MAX    = 439,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned JUMP_V   = 12,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic [3:0] is_Collision,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic [1:0] state,
    output logic       facing
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned VW = 5;
    localparam int unsigned XE = XW + 1;
    localparam int unsigned YE = YW + 1;
    localparam int unsigned VE = VW + 1;

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_RISE   = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;

    localparam logic [XW-1:0] X_INIT_V   = XW'(X_INIT);
    localparam logic [YW-1:0] Y_INIT_V   = YW'(Y_INIT);
    localparam logic [XW-1:0] X_MAX_V    = XW'(X_MAX);
    localparam logic [XE-1:0] X_MAX_E    = XE'(X_MAX);
    localparam logic [YW-1:0] Y_MAX_V    = YW'(Y_MAX);
    localparam logic [YE-1:0] Y_MAX_E    = YE'(Y_MAX);
    localparam logic [XE-1:0] SPEED_E    = XE'(SPEED);
    localparam logic [VW-1:0] JUMP_V_V   = VW'(JUMP_V);
    localparam logic [VE-1:0] GRAVITY_E  = VE'(GRAVITY);
    localparam logic [VW-1:0] MAX_FALL_V = VW'(MAX_FALL);
    localparam logic [VE-1:0] MAX_FALL_E = VE'(MAX_FALL);

    // architectural state
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [VW-1:0] r_vy;
    logic [1:0]    r_state;
    logic          r_facing;
    logic          r_jump_prev;

    // next-state values
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic [VW-1:0] w_vy_nxt;
    logic [1:0]    w_state_nxt;
    logic          w_facing_nxt;
    logic          w_jump_prev_nxt;
    logic          w_do_rise;

    // decoded inputs and one-bit-wider arithmetic
    logic          w_jedge;
    logic          w_left_only;
    logic          w_right_only;
    logic          w_air_jump;
    logic [XE-1:0] w_x_ext;
    logic [XE-1:0] w_x_inc;
    logic [XE-1:0] w_x_dec;
    logic [VW-1:0] w_rise_vy;
    logic [YE-1:0] w_y_ext;
    logic [YE-1:0] w_rise_vy_ext;
    logic [YE-1:0] w_y_rise;
    logic [YE-1:0] w_y_fall;
    logic [VE-1:0] w_vy_dec;
    logic [VE-1:0] w_vy_inc;

    assign w_jedge      = key_jump & ~r_jump_prev;
    assign w_left_only  = key_left & ~key_right;
    assign w_right_only = key_right & ~key_left;

    assign w_x_ext = {1'b0, r_x};
    assign w_x_inc = w_x_ext + SPEED_E;
    assign w_x_dec = w_x_ext - SPEED_E;

    // A jump from GROUND performs its first rise step with the fresh launch velocity.
    assign w_rise_vy     = (r_state == ST_GROUND) ? JUMP_V_V : r_vy;
    assign w_y_ext       = {1'b0, r_y};
    assign w_rise_vy_ext = YE'(w_rise_vy);
    assign w_y_rise      = w_y_ext - w_rise_vy_ext;
    assign w_y_fall      = w_y_ext + YE'(r_vy);
    assign w_vy_dec      = {1'b0, w_rise_vy} - GRAVITY_E;
    assign w_vy_inc      = {1'b0, r_vy} + GRAVITY_E;

`ifdef DOUBLE_JUMP_EN
    // Single airborne jump, re-armed on landing.
    logic r_air_used;

    assign w_air_jump = w_jedge & ~r_air_used &
                        ((r_state == ST_RISE) | (r_state == ST_FALL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_air_used <= 1'b0;
        end else if (frame_tick) begin
            if (w_air_jump) begin
                r_air_used <= 1'b1;
            end else if (w_state_nxt == ST_GROUND) begin
                r_air_used <= 1'b0;
            end
        end
    end
`else
    assign w_air_jump = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= X_INIT_V;
            r_y         <= Y_INIT_V;
            r_vy        <= '0;
            r_state     <= ST_FALL;
            r_facing    <= 1'b0;
            r_jump_prev <= 1'b0;
        end else begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_vy        <= w_vy_nxt;
            r_state     <= w_state_nxt;
            r_facing    <= w_facing_nxt;
            r_jump_prev <= w_jump_prev_nxt;
        end
    end

    // Next-state logic: everything holds unless this is the frame tick
    always_comb begin
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_vy_nxt        = r_vy;
        w_state_nxt     = r_state;
        w_facing_nxt    = r_facing;
        w_jump_prev_nxt = r_jump_prev;
        w_do_rise       = 1'b0;

        if (frame_tick) begin
            w_jump_prev_nxt = key_jump;

            // horizontal: facing follows the key even when a wall blocks motion
            if (w_left_only) begin
                w_facing_nxt = 1'b1;
                if (!is_Collision[3]) begin
                    w_x_nxt = (w_x_ext < SPEED_E) ? '0 : w_x_dec[XW-1:0];
                end
            end else if (w_right_only) begin
                w_facing_nxt = 1'b0;
                if (!is_Collision[2]) begin
                    w_x_nxt = (w_x_inc > X_MAX_E) ? X_MAX_V : w_x_inc[XW-1:0];
                end
            end

            // vertical
            if (w_air_jump) begin
                w_vy_nxt    = JUMP_V_V;
                w_state_nxt = ST_RISE;
            end else begin
                case (r_state)
                    ST_GROUND: begin
                        if (w_jedge) begin
                            w_do_rise = 1'b1;
                        end else if (!is_Collision[0]) begin
                            w_state_nxt = ST_FALL;
                            w_vy_nxt    = '0;
                        end
                    end
                    ST_RISE: begin
                        w_do_rise = 1'b1;
                    end
                    ST_FALL: begin
                        if (is_Collision[0]) begin
                            w_state_nxt = ST_GROUND;
                            w_vy_nxt    = '0;
                        end else if (w_y_fall > Y_MAX_E) begin
                            w_y_nxt     = Y_MAX_V;
                            w_vy_nxt    = '0;
                            w_state_nxt = ST_GROUND;
                        end else begin
                            w_y_nxt  = w_y_fall[YW-1:0];
                            w_vy_nxt = (w_vy_inc > MAX_FALL_E) ? MAX_FALL_V : w_vy_inc[VW-1:0];
                        end
                    end
                    default: begin
                        // unused encoding recovers to FALL
                        w_state_nxt = ST_FALL;
                        w_vy_nxt    = '0;
                    end
                endcase

                // rise step, shared by RISE and the launch tick out of GROUND
                if (w_do_rise) begin
                    if (is_Collision[1]) begin
                        w_state_nxt = ST_FALL;
                        w_vy_nxt    = '0;
                    end else if (w_y_ext < w_rise_vy_ext) begin
                        w_y_nxt     = '0;
                        w_vy_nxt    = '0;
                        w_state_nxt = ST_FALL;
                    end else begin
                        w_y_nxt = w_y_rise[YW-1:0];
                        // apex (or borrow) hands over to FALL
                        if (w_vy_dec[VW] || (w_vy_dec == '0)) begin
                            w_vy_nxt    = '0;
                            w_state_nxt = ST_FALL;
                        end else begin
                            w_vy_nxt    = w_vy_dec[VW-1:0];
                            w_state_nxt = ST_RISE;
                        end
                    end
                end
            end
        end
    end

    assign x_blue = r_x;
    assign y_blue = r_y;
    assign state  = r_state;
    assign facing = r_facing;

endmodule

// File: tb/tb_blue_motion.sv
// Self-checking bench for blue_motion: directed scenarios plus random stimulus,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
module tb_blue_motion;

    localparam int X_INIT = 40, Y_INIT = 400, X_MAX = 593, Y_MAX = 439;
    localparam int SPEED = 2, JUMP_V = 12, GRAVITY = 1, MAX_FALL = 8;
    localparam int S_GROUND = 0, S_RISE = 1, S_FALL = 2;
`ifdef DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_jump = 1'b0;
    logic [3:0] is_Collision = 4'd0;
    logic [9:0] x_blue;
    logic [8:0] y_blue;
    logic [1:0] state;
    logic       facing;

    blue_motion dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_jump     (key_jump),
        .is_Collision (is_Collision),
        .x_blue       (x_blue),
        .y_blue       (y_blue),
        .state        (state),
        .facing       (facing)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int st;
        int face;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic rst_req = 1'b0;

    // behavioural model state
    int m_x, m_y, m_vy, m_st, m_face, m_jprev, m_air;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = X_INIT; m_y = Y_INIT; m_vy = 0; m_st = S_FALL;
        m_face = 0; m_jprev = 0; m_air = 0;
    endtask

    task automatic model_rise(input logic head);
        if (head) begin
            m_st = S_FALL; m_vy = 0;
        end else if (m_y < m_vy) begin
            m_y = 0; m_vy = 0; m_st = S_FALL;
        end else begin
            m_y  = m_y - m_vy;
            m_vy = m_vy - GRAVITY;
            m_st = (m_vy <= 0) ? S_FALL : S_RISE;
            if (m_vy < 0) m_vy = 0;
        end
    endtask

    task automatic model_step(input logic t, input logic l, input logic r,
                              input logic j, input logic [3:0] c);
        bit jedge;
        if (!t) return;
        jedge   = j && (m_jprev == 0);
        m_jprev = int'(j);
        if (l && !r) begin
            m_face = 1;
            if (!c[3]) m_x = (m_x < SPEED) ? 0 : m_x - SPEED;
        end else if (r && !l) begin
            m_face = 0;
            if (!c[2]) m_x = (m_x + SPEED > X_MAX) ? X_MAX : m_x + SPEED;
        end
        if (DJ && jedge && m_air == 0 && (m_st == S_RISE || m_st == S_FALL)) begin
            m_vy = JUMP_V; m_st = S_RISE; m_air = 1;
        end else if (m_st == S_GROUND) begin
            if (jedge) begin
                m_vy = JUMP_V;
                model_rise(c[1]);
            end else if (!c[0]) begin
                m_st = S_FALL; m_vy = 0;
            end
        end else if (m_st == S_RISE) begin
            model_rise(c[1]);
        end else begin
            if (c[0]) begin
                m_st = S_GROUND; m_vy = 0;
            end else if (m_y + m_vy > Y_MAX) begin
                m_y = Y_MAX; m_vy = 0; m_st = S_GROUND;
            end else begin
                m_y  = m_y + m_vy;
                m_vy = (m_vy + GRAVITY > MAX_FALL) ? MAX_FALL : m_vy + GRAVITY;
            end
        end
        if (m_st == S_GROUND) m_air = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.x = m_x; e.y = m_y; e.st = m_st; e.face = m_face;
        q.push_back(e);
    endtask

    // one clock of stimulus; expected post-edge outputs go to the scoreboard
    task automatic drive(input logic t, input logic l, input logic r,
                         input logic j, input logic [3:0] c);
        @(negedge clk);
        rst_n = rst_req;
        frame_tick = t; key_left = l; key_right = r; key_jump = j; is_Collision = c;
        if (!rst_n) model_reset();
        else model_step(t, l, r, j, c);
        push_exp();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // asynchronous reset between edges, held across three ticks
    task automatic do_reset();
        @(negedge clk);
        rst_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_x", int'(x_blue), X_INIT);
        chk("rst_y", int'(y_blue), Y_INIT);
        chk("rst_state", int'(state), S_FALL);
        chk("rst_facing", int'(facing), 0);
        model_reset();
        push_exp();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom));
        rst_req = 1'b1;
    endtask

    // monitor: every clock the DUT presents an output, compare it to the head of the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_x", int'(x_blue), e.x);
                chk("sb_y", int'(y_blue), e.y);
                chk("sb_state", int'(state), e.st);
                chk("sb_facing", int'(facing), e.face);
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   hit;
        int   exp_y [3];
        logic [3:0] c;
        exp_y[0] = 351; exp_y[1] = 353; exp_y[2] = 356;
        model_reset();

        do_reset();

        // walk right on the floor, with idle cycles between ticks
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 4'($urandom));
        end
        settle();
        chk("walk_x", int'(x_blue), 60);
        chk("walk_y", int'(y_blue), 400);
        chk("walk_state", int'(state), S_GROUND);
        chk("walk_facing", int'(facing), 0);

        // full jump arc
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        settle();
        chk("jump_t1_y", int'(y_blue), 388);
        chk("jump_t1_state", int'(state), S_RISE);
        for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        settle();
        chk("apex_y", int'(y_blue), 322);
        chk("apex_state", int'(state), S_FALL);

        // free fall lands on the bottom clamp
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
            settle();
            hit = (state == 2'd0);
        end
        chk("land_reached", int'(hit), 1);
        chk("land_y", int'(y_blue), Y_MAX);

        // second jump edge while airborne
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        settle();
`ifdef DOUBLE_JUMP_EN
        chk("air_jump_y", int'(y_blue), 416);
`else
        chk("air_jump_y", int'(y_blue), 406);
`endif
        chk("air_jump_state", int'(state), S_RISE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

        // reset mid-jump
        do_reset();

        // head bump at y=350
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        settle();
        chk("rise_y", int'(y_blue), 350);
        chk("rise_state", int'(state), S_RISE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010);
        settle();
        chk("head_y", int'(y_blue), 350);
        chk("head_state", int'(state), S_FALL);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
            settle();
            chk("head_fall_y", int'(y_blue), exp_y[i]);
        end

        // right clamp, right wall, left clamp
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
            settle();
            hit = (x_blue == 10'd592);
        end
        chk("reach_592", int'(hit), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        settle();
        chk("clamp_xmax", int'(x_blue), X_MAX);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0101);
        settle();
        chk("wall_right_x", int'(x_blue), X_MAX);
        chk("wall_right_facing", int'(facing), 0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001);
            settle();
            hit = (x_blue == 10'd1);
        end
        chk("reach_1", int'(hit), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001);
        settle();
        chk("clamp_x0", int'(x_blue), 0);
        chk("left_facing", int'(facing), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1001);
        settle();
        chk("wall_left_x", int'(x_blue), 2);

        // random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            c = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 0)};
            drive(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), c);
            if (i == 1200) do_reset();
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        settle();
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
